xgmii_pack_nx: RTL and testbench



---
 rtl/gtype_pkg.sv | 32 +++
 rtl/xgmii_pack_nx_idle_timer.sv | 47 ++++
 rtl/xgmii_pack_nx.sv | 208 ++++++++++++++++++++
 tb/tb_xgmii_pack_nx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gtype_pkg.sv
//==============================================================================
// Module      : gtype (package)
// Description : Shared XGMII character constants, word types and the packer
//               frame-state encoding.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package gtype;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  ctrl;
  } xgmii32_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  ctrl;
  } xgmii64_t;

  typedef enum logic [0:0] {
    ST_OUTSIDE = 1'b0,
    ST_INFRAME = 1'b1
  } frame_state_t;

endpackage

`default_nettype wire

// File: rtl/xgmii_pack_nx_idle_timer.sv
//==============================================================================
// Module      : xgmii_idle_timer
// Description : Counts enabled idle cycles and pulses expire on the FLUSH_TO-th
//               one. FLUSH_TO = 0 disables the timer entirely.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module xgmii_idle_timer #(
  parameter int FLUSH_TO = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  generate
    if (FLUSH_TO == 0) begin : g_off
      logic w_unused;
      assign w_unused = &{1'b0, clk, rst, en, clr};
      assign expire   = 1'b0;
    end else begin : g_on
      localparam int c_cw = $clog2(FLUSH_TO + 1);

      logic [c_cw-1:0] r_cnt;

      // Fires combinationally in the FLUSH_TO-th enabled cycle so the flush
      // is registered on that same edge.
      assign expire = en && !clr && (r_cnt == c_cw'(FLUSH_TO - 1));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (clr || expire) begin
          r_cnt <= '0;
        end else if (en) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/xgmii_pack_nx.sv
//==============================================================================
// Module      : xgmii_pack_nx
// Description : Packs RATIO narrow XGMII words into one wide word, keeping /S/
//               on lane 0 by idle padding. Optional pad/flush counter built
//               when XGMII_PACK_PAD_CNT_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module xgmii_pack_nx
  import gtype::*;
#(
  parameter int LANES_IN = 4,
  parameter int RATIO    = 2,
  parameter int FLUSH_TO = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LANES_IN*8-1:0]        rx_data,
  input  logic [LANES_IN-1:0]          rx_ctrl,
  input  logic                         rx_ena,
  output logic [LANES_IN*RATIO*8-1:0]  tx_data,
  output logic [LANES_IN*RATIO-1:0]    tx_ctrl,
  output logic                         tx_ena
`ifdef XGMII_PACK_PAD_CNT_EN
  ,
  output logic [15:0]                  pad_cnt
`endif
);

  localparam int c_w  = LANES_IN * 8;
  localparam int c_ow = c_w * RATIO;
  localparam int c_ol = LANES_IN * RATIO;
  localparam logic [c_ow-1:0] c_idle_data = {c_ol{XGMII_IDLE}};

  logic            r_tx_ena;
  logic [c_ow-1:0] r_tx_data;
  logic [c_ol-1:0] r_tx_ctrl;

`ifdef XGMII_PACK_PAD_CNT_EN
  logic w_pad_evt;
`endif

  generate
    if (RATIO == 1) begin : g_pass
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_tx_ena  <= 1'b0;
          r_tx_data <= c_idle_data;
          r_tx_ctrl <= '1;
        end else begin
          r_tx_ena <= rx_ena;
          if (rx_ena) begin
            r_tx_data <= rx_data;
            r_tx_ctrl <= rx_ctrl;
          end
        end
      end
`ifdef XGMII_PACK_PAD_CNT_EN
      assign w_pad_evt = 1'b0;
`endif
    end else begin : g_pack
      localparam int c_sw = $clog2(RATIO);

      logic [c_sw-1:0] r_slot;
      logic [c_ow-1:0] r_buf_data;
      logic [c_ol-1:0] r_buf_ctrl;
      frame_state_t    r_state;
      frame_state_t    w_state_nxt;

      logic            w_start;
      logic            w_term;
      logic            w_spad;
      logic            w_full;
      logic            w_tmo_en;
      logic            w_tmo_exp;
      logic [c_ow-1:0] w_pad_data;
      logic [c_ol-1:0] w_pad_ctrl;
      logic [c_ow-1:0] w_full_data;
      logic [c_ol-1:0] w_full_ctrl;

      always_comb begin
        w_start = rx_ena && rx_ctrl[0] && (rx_data[7:0] == XGMII_START);
        w_term  = 1'b0;
        for (int l = 0; l < LANES_IN; l++) begin
          if (rx_ena && rx_ctrl[l] && (rx_data[l*8 +: 8] == XGMII_TERM)) begin
            w_term = 1'b1;
          end
        end
        w_spad = w_start && (r_slot != '0);
        w_full = rx_ena && !w_spad && (r_slot == c_sw'(RATIO - 1));

        // Padded view fills unwritten slots with idle; full view drops the
        // incoming word into the last slot.
        w_pad_data  = r_buf_data;
        w_pad_ctrl  = r_buf_ctrl;
        w_full_data = r_buf_data;
        w_full_ctrl = r_buf_ctrl;
        for (int s = 0; s < RATIO; s++) begin
          if (c_sw'(s) >= r_slot) begin
            w_pad_data[s*c_w +: c_w]           = {LANES_IN{XGMII_IDLE}};
            w_pad_ctrl[s*LANES_IN +: LANES_IN] = '1;
          end
          if (c_sw'(s) == r_slot) begin
            w_full_data[s*c_w +: c_w]           = rx_data;
            w_full_ctrl[s*LANES_IN +: LANES_IN] = rx_ctrl;
          end
        end
      end

      // /T/ wins over /S/ in the same word so the frame ends OUTSIDE.
      always_comb begin
        w_state_nxt = r_state;
        if (w_term) begin
          w_state_nxt = ST_OUTSIDE;
        end else if (w_start) begin
          w_state_nxt = ST_INFRAME;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state <= ST_OUTSIDE;
        end else begin
          r_state <= w_state_nxt;
        end
      end

      assign w_tmo_en = !rx_ena && (r_state == ST_OUTSIDE) && (r_slot != '0);

      xgmii_idle_timer #(
        .FLUSH_TO (FLUSH_TO)
      ) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .en     (w_tmo_en),
        .clr    (rx_ena),
        .expire (w_tmo_exp)
      );

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_slot     <= '0;
          r_buf_data <= c_idle_data;
          r_buf_ctrl <= '1;
          r_tx_ena   <= 1'b0;
          r_tx_data  <= c_idle_data;
          r_tx_ctrl  <= '1;
        end else begin
          r_tx_ena <= 1'b0;
          if (w_spad) begin
            r_tx_ena                 <= 1'b1;
            r_tx_data                <= w_pad_data;
            r_tx_ctrl                <= w_pad_ctrl;
            r_buf_data[c_w-1:0]      <= rx_data;
            r_buf_ctrl[LANES_IN-1:0] <= rx_ctrl;
            r_slot                   <= c_sw'(1);
          end else if (rx_ena) begin
            for (int s = 0; s < RATIO; s++) begin
              if (c_sw'(s) == r_slot) begin
                r_buf_data[s*c_w +: c_w]           <= rx_data;
                r_buf_ctrl[s*LANES_IN +: LANES_IN] <= rx_ctrl;
              end
            end
            if (w_full) begin
              r_tx_ena  <= 1'b1;
              r_tx_data <= w_full_data;
              r_tx_ctrl <= w_full_ctrl;
              r_slot    <= '0;
            end else begin
              r_slot <= r_slot + 1'b1;
            end
          end else if (w_tmo_exp) begin
            r_tx_ena  <= 1'b1;
            r_tx_data <= w_pad_data;
            r_tx_ctrl <= w_pad_ctrl;
            r_slot    <= '0;
          end
        end
      end

`ifdef XGMII_PACK_PAD_CNT_EN
      assign w_pad_evt = w_spad || w_tmo_exp;
`endif
    end
  endgenerate

  assign tx_ena  = r_tx_ena;
  assign tx_data = r_tx_data;
  assign tx_ctrl = r_tx_ctrl;

`ifdef XGMII_PACK_PAD_CNT_EN
  logic [15:0] r_pad_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pad_cnt <= '0;
    end else if (w_pad_evt && (r_pad_cnt != 16'hFFFF)) begin
      r_pad_cnt <= r_pad_cnt + 16'd1;
    end
  end

  assign pad_cnt = r_pad_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_xgmii_pack_nx.sv
//==============================================================================
// Module      : tb_xgmii_pack_nx
// Description : Self-checking bench for xgmii_pack_nx (RATIO=2 and RATIO=1
//               instances) against a queue-style packing model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_xgmii_pack_nx;

  localparam int R  = 2;
  localparam int FT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rx_data;
  logic [3:0]  rx_ctrl;
  logic        rx_ena;
  logic [63:0] tx_data;
  logic [7:0]  tx_ctrl;
  logic        tx_ena;
  logic [31:0] tx1_data;
  logic [3:0]  tx1_ctrl;
  logic        tx1_ena;
`ifdef XGMII_PACK_PAD_CNT_EN
  logic [15:0] pad_cnt;
  logic [15:0] pad1_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  always #5 clk = ~clk;

  xgmii_pack_nx #(.LANES_IN(4), .RATIO(R), .FLUSH_TO(FT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ctrl(rx_ctrl), .rx_ena(rx_ena),
    .tx_data(tx_data), .tx_ctrl(tx_ctrl), .tx_ena(tx_ena)
`ifdef XGMII_PACK_PAD_CNT_EN
    , .pad_cnt(pad_cnt)
`endif
  );

  xgmii_pack_nx #(.LANES_IN(4), .RATIO(1), .FLUSH_TO(FT)) dut1 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ctrl(rx_ctrl), .rx_ena(rx_ena),
    .tx_data(tx1_data), .tx_ctrl(tx1_ctrl), .tx_ena(tx1_ena)
`ifdef XGMII_PACK_PAD_CNT_EN
    , .pad_cnt(pad1_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: list of pending narrow words, flushed as one wide word.
  int          m_n;
  int          m_idle;
  bit          m_inframe;
  bit          m_st;
  bit          m_tm;
  logic [31:0] m_pd[R];
  logic [3:0]  m_pc[R];
  logic        exp_ena;
  logic [63:0] exp_data;
  logic [7:0]  exp_ctrl;
  int          exp_pad;
  logic        e1_ena;
  logic [31:0] e1_data;
  logic [3:0]  e1_ctrl;

  task automatic m_emit(input bit pad);
    for (int s = 0; s < R; s++) begin
      if (s < m_n) begin
        exp_data[s*32 +: 32] = m_pd[s];
        exp_ctrl[s*4 +: 4]   = m_pc[s];
      end else begin
        exp_data[s*32 +: 32] = 32'h07070707;
        exp_ctrl[s*4 +: 4]   = 4'hF;
      end
    end
    exp_ena = 1'b1;
    m_n     = 0;
    if (pad && exp_pad < 65535) exp_pad++;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n = 0; m_idle = 0; m_inframe = 1'b0; exp_pad = 0;
      exp_ena = 1'b0; exp_data = {8{8'h07}}; exp_ctrl = 8'hFF;
      e1_ena = 1'b0; e1_data = 32'h07070707; e1_ctrl = 4'hF;
    end else begin
      exp_ena = 1'b0;
      e1_ena  = rx_ena;
      if (rx_ena) begin
        e1_data = rx_data;
        e1_ctrl = rx_ctrl;
        m_idle  = 0;
        m_st    = rx_ctrl[0] && rx_data[7:0] == 8'hFB;
        m_tm    = 1'b0;
        for (int l = 0; l < 4; l++)
          if (rx_ctrl[l] && rx_data[l*8 +: 8] == 8'hFD) m_tm = 1'b1;
        if (m_st && m_n > 0) m_emit(1'b1);
        m_pd[m_n] = rx_data;
        m_pc[m_n] = rx_ctrl;
        m_n++;
        if (m_n == R) m_emit(1'b0);
        if (m_tm) m_inframe = 1'b0;
        else if (m_st) m_inframe = 1'b1;
      end else if (!m_inframe && m_n > 0) begin
        m_idle++;
        if (m_idle == FT) begin
          m_emit(1'b1);
          m_idle = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("tx_ena", 64'(tx_ena), 64'(exp_ena));
      chk("tx_data", tx_data, exp_data);
      chk("tx_ctrl", 64'(tx_ctrl), 64'(exp_ctrl));
      chk("r1_ena", 64'(tx1_ena), 64'(e1_ena));
      chk("r1_data", 64'(tx1_data), 64'(e1_data));
      chk("r1_ctrl", 64'(tx1_ctrl), 64'(e1_ctrl));
`ifdef XGMII_PACK_PAD_CNT_EN
      chk("pad_cnt", 64'(pad_cnt), 64'(exp_pad));
      chk("r1_pad_cnt", 64'(pad1_cnt), 64'd0);
`endif
    end
  end

  task automatic step(input logic ena, input logic [31:0] d, input logic [3:0] c);
    rx_ena  = ena;
    rx_data = d;
    rx_ctrl = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_ena = 1'b0;
    #1;
    chk("rst_ena", 64'(tx_ena), 64'd0);
    chk("rst_data", tx_data, 64'h0707070707070707);
    chk("rst_ctrl", 64'(tx_ctrl), 64'hFF);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  localparam logic [31:0] c_st = 32'h555555FB;
  localparam logic [31:0] c_tm = 32'h070707FD;
  localparam logic [31:0] c_id = 32'h07070707;

  initial begin
    rst = 1'b1; rx_ena = 1'b0; rx_data = '0; rx_ctrl = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_on = 1'b1;
    do_reset();

    // Aligned frame: 8 words -> 4 outputs.
    step(1'b1, c_st, 4'h1);
    chk("al_hold", 64'(tx_ena), 64'd0);
    chk("r1_echo", 64'(tx1_data), 64'(c_st));
    step(1'b1, 32'hA0A0A0A1, 4'h0);
    chk("al_w0_ena", 64'(tx_ena), 64'd1);
    chk("al_w0", tx_data, {32'hA0A0A0A1, c_st});
    for (int i = 2; i < 7; i++) step(1'b1, 32'hA0A0A0A0 + 32'(i), 4'h0);
    step(1'b1, c_tm, 4'hF);
    chk("al_w3", tx_data, {c_tm, 32'hA0A0A0A6});
`ifdef XGMII_PACK_PAD_CNT_EN
    chk("al_pad", 64'(pad_cnt), 64'd0);
`endif

    // Misaligned start.
    step(1'b1, c_id, 4'hF);
    step(1'b1, c_st, 4'h1);
    chk("mis_pad_ena", 64'(tx_ena), 64'd1);
    chk("mis_pad_data", tx_data, 64'h0707070707070707);
    chk("mis_pad_ctrl", 64'(tx_ctrl), 64'hFF);
    step(1'b1, 32'hC0DEC0DE, 4'h0);
    chk("mis_start", tx_data, {32'hC0DEC0DE, c_st});
    chk("mis_ctrl", 64'(tx_ctrl), 64'h01);
`ifdef XGMII_PACK_PAD_CNT_EN
    chk("mis_pad", 64'(pad_cnt), 64'd1);
`endif
    step(1'b1, c_tm, 4'hF);
    step(1'b1, c_id, 4'hF);

    // Idle timeout.
    step(1'b1, c_id, 4'hF);
    for (int i = 1; i < FT; i++) begin
      step(1'b0, 32'h0, 4'h0);
      chk("to_early", 64'(tx_ena), 64'd0);
    end
    step(1'b0, 32'h0, 4'h0);
    chk("to_fire", 64'(tx_ena), 64'd1);
    chk("to_data", tx_data, 64'h0707070707070707);
`ifdef XGMII_PACK_PAD_CNT_EN
    chk("to_pad", 64'(pad_cnt), 64'd2);
`endif

    // No timeout while in frame.
    step(1'b1, c_st, 4'h1);
    repeat (100) step(1'b0, 32'h0, 4'h0);
    step(1'b1, 32'h12345678, 4'h0);
    chk("inf_ena", 64'(tx_ena), 64'd1);
    chk("inf_data", tx_data, {32'h12345678, c_st});
    step(1'b1, c_tm, 4'hF);
    step(1'b1, c_id, 4'hF);

    // Reset mid-word, then no flush.
    step(1'b1, 32'h0BADF00D, 4'h0);
    do_reset();
    repeat (FT + 4) step(1'b0, 32'h0, 4'h0);
    chk("rstmid_ena", 64'(tx_ena), 64'd0);
    chk("rstmid_data", tx_data, 64'h0707070707070707);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int r;
      int k;
      logic [31:0] d;
      logic [3:0]  c;
      r = $urandom_range(0, 99);
      d = $urandom;
      c = 4'($urandom);
      if (r < 3) begin
        repeat ($urandom_range(10, 24)) step(1'b0, d, c);
      end else if (r < 30) begin
        step(1'b0, d, c);
      end else if (r < 40) begin
        step(1'b1, {d[31:8], 8'hFB}, {c[3:1], 1'b1});
      end else if (r < 50) begin
        k = $urandom_range(0, 3);
        d[k*8 +: 8] = 8'hFD;
        c[k] = 1'b1;
        step(1'b1, d, c);
      end else if (r < 65) begin
        step(1'b1, c_id, 4'hF);
      end else begin
        step(1'b1, d, 4'h0);
      end
    end

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
